// File: rtl/arm7tdmi_shift_ctrl.sv
// Shift sequencer in front of the combinational arm7tdmi_shifter: extra Rs cycle, amount fix-ups, valid/ready result.
// Optional RS_WAIT stall counter enabled by defining ARM7_SHIFT_CTRL_STATS_EN.
module arm7tdmi_shift_ctrl #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_type,
    input  logic        req_is_reg,
    input  logic [7:0]  req_amount,
    input  logic        req_carry,
    output logic [31:0] sh_data,
    output logic [1:0]  sh_type,
    output logic [4:0]  sh_amount,
    output logic        sh_carry_in,
    input  logic [31:0] sh_data_out,
    input  logic        sh_carry_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry
`ifdef ARM7_SHIFT_CTRL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, RS_WAIT, RESP} state_t;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_type_t;

    if (STALL_CNT_W < 1) begin : g_bad_param
        $error("STALL_CNT_W must be at least 1");
    end

    state_t      state, state_next;
    logic [31:0] lat_data;
    logic [1:0]  lat_type;
    logic [7:0]  lat_amount;
    logic        lat_is_reg;
    logic        lat_carry;

    logic [31:0] op_data;
    shift_type_t op_type;
    logic [7:0]  op_amount;
    logic        op_is_reg;
    logic        op_carry;
    logic        drive_sh;
    logic        use_sh;
    logic [4:0]  amt5;
    logic [31:0] fix_data;
    logic        fix_carry;
    logic        accept;
    logic        capture;

    // Immediates are registered at the accept edge, so in IDLE the shifter sees the live request.
    always_comb begin
        if (state == IDLE) begin
            op_data   = req_data;
            op_type   = shift_type_t'(req_type);
            op_amount = req_amount;
            op_is_reg = req_is_reg;
            op_carry  = req_carry;
        end else begin
            op_data   = lat_data;
            op_type   = shift_type_t'(lat_type);
            op_amount = lat_amount;
            op_is_reg = lat_is_reg;
            op_carry  = lat_carry;
        end
    end

    // Non-shifter cases park the shifter on amount 1 so it never sees LSL/LSR/ASR #0.
    always_comb begin
        use_sh    = 1'b0;
        amt5      = 5'd1;
        fix_data  = op_data;
        fix_carry = op_carry;
        if (!op_is_reg) begin
            if (op_amount[4:0] != 5'd0) begin
                use_sh = 1'b1;
                amt5   = op_amount[4:0];
            end else begin
                unique case (op_type)
                    SH_LSL: ;
                    SH_LSR: begin
                        fix_data  = '0;
                        fix_carry = op_data[31];
                    end
                    SH_ASR: begin
                        fix_data  = {32{op_data[31]}};
                        fix_carry = op_data[31];
                    end
                    SH_ROR: begin
                        use_sh = 1'b1;
                        amt5   = 5'd0;
                    end
                endcase
            end
        end else if (op_amount != 8'd0) begin
            unique case (op_type)
                SH_LSL: begin
                    if (op_amount < 8'd32) begin
                        use_sh = 1'b1;
                        amt5   = op_amount[4:0];
                    end else begin
                        fix_data  = '0;
                        fix_carry = (op_amount == 8'd32) ? op_data[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (op_amount < 8'd32) begin
                        use_sh = 1'b1;
                        amt5   = op_amount[4:0];
                    end else begin
                        fix_data  = '0;
                        fix_carry = (op_amount == 8'd32) ? op_data[31] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (op_amount < 8'd32) begin
                        use_sh = 1'b1;
                        amt5   = op_amount[4:0];
                    end else begin
                        fix_data  = {32{op_data[31]}};
                        fix_carry = op_data[31];
                    end
                end
                SH_ROR: begin
                    if (op_amount[4:0] != 5'd0) begin
                        use_sh = 1'b1;
                        amt5   = op_amount[4:0];
                    end else begin
                        fix_carry = op_data[31];
                    end
                end
            endcase
        end
    end

    assign drive_sh    = (state != IDLE) || req_valid;
    assign sh_data     = drive_sh ? op_data : '0;
    assign sh_type     = drive_sh ? op_type : '0;
    assign sh_amount   = drive_sh ? amt5 : '0;
    assign sh_carry_in = drive_sh ? op_carry : 1'b0;

    assign accept  = (state == IDLE) && req_valid;
    assign capture = (accept && !req_is_reg) || (state == RS_WAIT);

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_is_reg ? RS_WAIT : RESP;
            end
            RS_WAIT: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_data   <= '0;
            lat_type   <= '0;
            lat_amount <= '0;
            lat_is_reg <= 1'b0;
            lat_carry  <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_data   <= req_data;
                lat_type   <= req_type;
                lat_amount <= req_amount;
                lat_is_reg <= req_is_reg;
                lat_carry  <= req_carry;
            end
            if (capture) begin
                rsp_data  <= use_sh ? sh_data_out : fix_data;
                rsp_carry <= use_sh ? sh_carry_out : fix_carry;
            end
        end
    end

`ifdef ARM7_SHIFT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (state == RS_WAIT && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
